// File: rtl/bpred_pkg.sv
// Shared types and constants for the branch-predictor controller:
// 2-bit saturating counter type and encodings, FSM state enum,
// and the queued update record.
package bpred_pkg;

    // Index width of the update record; the controller's IDX_W defaults to this.
    localparam int BPRED_IDX_W = 4;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;  // strongly not-taken
    localparam ctr_t WNT = 2'b01;  // weakly not-taken
    localparam ctr_t WT  = 2'b10;  // weakly taken
    localparam ctr_t ST  = 2'b11;  // strongly taken

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [BPRED_IDX_W-1:0] idx;
        logic                   taken;
    } upd_rec_t;

    // Saturating train step: move toward the outcome, hold at the rails.
    function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken && cur != ST) begin
            nxt = cur + 2'd1;
        end else if (!taken && cur != SNT) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_ctrl_if.sv
// Lookup / prediction / update bundle of the branch-predictor controller.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// ready never depends on the same channel's valid, and a valid request is
// held stable until it is accepted.
interface bpred_ctrl_if
    import bpred_pkg::*;
#(
    parameter int IDX_W  = BPRED_IDX_W,
    parameter int MCNT_W = 16
);
    logic              lookup_valid;
    logic              lookup_ready;
    logic [IDX_W-1:0]  lookup_idx;
    logic              pred_valid;
    logic [IDX_W-1:0]  pred_idx;
    logic              pred_taken;
    logic              upd_valid;
    logic              upd_ready;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              init_busy;
    logic [MCNT_W-1:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken,
        input  lookup_ready, pred_valid, pred_idx, pred_taken, upd_ready,
               init_busy, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_idx, upd_valid, upd_idx, upd_taken,
        output lookup_ready, pred_valid, pred_idx, pred_taken, upd_ready,
               init_busy, mispredict_count
    );
endinterface

// File: rtl/bpred_upd_fifo.sv
// Two-entry FIFO of update records. Both slots and their valid flags are
// exposed so the owner can search queued indices.
module bpred_upd_fifo
    import bpred_pkg::*;
#(
    parameter type rec_t = upd_rec_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic       pop_i,
    input  rec_t       wr_data_i,
    output rec_t       rd_data_o,
    output rec_t       slot0_o,
    output rec_t       slot1_o,
    output logic [1:0] slot_vld_o,
    output logic       full_o,
    output logic       empty_o
);
    rec_t       mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_data_o     = mem_q[rd_ptr_q];
    assign slot0_o       = mem_q[0];
    assign slot1_o       = mem_q[1];
    assign slot_vld_o[0] = full_o || (cnt_q == 2'd1 && rd_ptr_q == 1'b0);
    assign slot_vld_o[1] = full_o || (cnt_q == 2'd1 && rd_ptr_q == 1'b1);

    // Pointer and occupancy bookkeeping; push+pop together leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Record storage; contents are qualified by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/bpred_ctrl.sv
// Branch-predictor controller: table of 2-bit counters, cleared by an INIT
// sweep, then served to lookups and trained from a 2-deep update FIFO with
// one table access per cycle. Optional macro BPRED_FWD_EN stalls lookups
// whose index is still queued for training until the queue drains.
module bpred_ctrl
    import bpred_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = BPRED_IDX_W,
    parameter int MCNT_W  = 16
) (
    input logic         clk,
    input logic         reset,
    bpred_ctrl_if.slave bus
);
`ifdef BPRED_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    state_e            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic              init_busy_q;
    ctr_t              tbl_q [ENTRIES];
    logic              pred_valid_q;
    logic [IDX_W-1:0]  pred_idx_q;
    logic              pred_taken_q;
    logic [MCNT_W-1:0] mcnt_q;

    upd_rec_t   push_rec;
    upd_rec_t   head;
    upd_rec_t   slot0;
    upd_rec_t   slot1;
    logic [1:0] slot_vld;
    logic       full;
    logic       empty;
    logic       run;
    logic       push;
    logic       pop;
    logic       fwd_match;
    logic       lookup_fire;
    ctr_t       head_ctr;
    ctr_t       head_nxt;

    assign run       = (state_q == RUN);
    assign fwd_match = (slot_vld[0] && slot0.idx == bus.lookup_idx) ||
                       (slot_vld[1] && slot1.idx == bus.lookup_idx);

    // A full queue forces a drain; otherwise lookups have priority.
    assign bus.lookup_ready = run && !full && !(FwdEn && fwd_match);
    assign bus.upd_ready    = run && !full;
    assign lookup_fire      = bus.lookup_valid && bus.lookup_ready;
    assign push             = bus.upd_valid && bus.upd_ready;
    assign pop              = run && !empty && !lookup_fire;

    assign push_rec = '{idx: bus.upd_idx, taken: bus.upd_taken};
    assign head_ctr = tbl_q[head.idx];
    assign head_nxt = ctr_next(head_ctr, head.taken);

    assign bus.pred_valid       = pred_valid_q;
    assign bus.pred_idx         = pred_idx_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.init_busy        = init_busy_q;
    assign bus.mispredict_count = mcnt_q;

    bpred_upd_fifo #(.rec_t(upd_rec_t)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .wr_data_i  (push_rec),
        .rd_data_o  (head),
        .slot0_o    (slot0),
        .slot1_o    (slot1),
        .slot_vld_o (slot_vld),
        .full_o     (full),
        .empty_o    (empty)
    );

    // INIT/RUN sequencing: sweep every entry once, then serve traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            ptr_q       <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == IDX_W'(ENTRIES - 1)) begin
                        state_q     <= RUN;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Single table write port: sweep clear during INIT, training on drain in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                tbl_q[ptr_q] <= SNT;
            end else if (pop) begin
                tbl_q[head.idx] <= head_nxt;
            end
        end
    end

    // Registered prediction response and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_taken_q <= 1'b0;
            mcnt_q       <= '0;
        end else begin
            pred_valid_q <= lookup_fire;
            if (lookup_fire) begin
                pred_idx_q   <= bus.lookup_idx;
                pred_taken_q <= tbl_q[bus.lookup_idx][1];
            end
            if (pop && head.taken != head_ctr[1] && mcnt_q != '1) begin
                mcnt_q <= mcnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bpred_ctrl.sv
// Directed bench for bpred_ctrl: reset/INIT sweep, training up and down,
// arbitration under back-to-back updates, reset with queued updates, and
// the lookup-vs-queued-update behaviour selected by BPRED_FWD_EN.
module tb_bpred_ctrl;
    logic clk;
    logic reset;
    int   passed;
    int   total;
    int   exp_mcnt;

    bpred_ctrl_if #(.IDX_W(4), .MCNT_W(16)) bus ();

    bpred_ctrl #(.ENTRIES(16), .IDX_W(4), .MCNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_update(input logic [3:0] idx, input logic taken);
        int n;
        bus.upd_valid = 1'b1;
        bus.upd_idx   = idx;
        bus.upd_taken = taken;
        #1;
        n = 0;
        while (!bus.upd_ready && n < 50) begin
            tick();
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL upd_timeout: upd_ready stayed %b, expected 1", bus.upd_ready);
        end
        tick();
        bus.upd_valid = 1'b0;
        idle(2);
    endtask

    task automatic do_lookup(input logic [3:0] idx, output logic pv,
                             output logic [3:0] pi, output logic pt);
        int n;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = idx;
        #1;
        n = 0;
        while (!bus.lookup_ready && n < 50) begin
            tick();
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            $display("FAIL lookup_timeout: lookup_ready stayed %b, expected 1", bus.lookup_ready);
        end
        tick();
        bus.lookup_valid = 1'b0;
        #1;
        pv = bus.pred_valid;
        pi = bus.pred_idx;
        pt = bus.pred_taken;
    endtask

    task automatic count_init(input string tag);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (bus.init_busy && n < 40) begin
            if (bus.lookup_ready || bus.upd_ready) bad++;
            tick();
            #1;
            n++;
        end
        bus.lookup_valid = 1'b0;
        total++;
        if (n !== 16) $display("FAIL %s_init_cycles: got %0d, expected 16", tag, n);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL %s_ready_in_init: got %0d cycles with ready, expected 0", tag, bad);
        else passed++;
    endtask

    task automatic test_reset();
        logic pv;
        logic [3:0] pi;
        logic pt;
        reset = 1'b1;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = 4'd5;
        tick();
        tick();
        #1;
        total++;
        if (bus.init_busy !== 1'b1) $display("FAIL rst_init_busy: got %b expected 1", bus.init_busy);
        else passed++;
        total++;
        if (bus.lookup_ready !== 1'b0) $display("FAIL rst_lookup_ready: got %b expected 0", bus.lookup_ready);
        else passed++;
        total++;
        if (bus.upd_ready !== 1'b0) $display("FAIL rst_upd_ready: got %b expected 0", bus.upd_ready);
        else passed++;
        total++;
        if ({bus.pred_valid, bus.pred_idx, bus.pred_taken} !== 6'd0)
            $display("FAIL rst_pred: got v=%b i=%0d t=%b expected all 0", bus.pred_valid, bus.pred_idx, bus.pred_taken);
        else passed++;
        total++;
        if (bus.mispredict_count !== 16'd0) $display("FAIL rst_mcnt: got %0d expected 0", bus.mispredict_count);
        else passed++;
        reset = 1'b0;
        count_init("boot");
        do_lookup(4'd5, pv, pi, pt);
        total++;
        if ({pv, pi, pt} !== {1'b1, 4'd5, 1'b0})
            $display("FAIL lookup5: got v=%b i=%0d t=%b expected v=1 i=5 t=0", pv, pi, pt);
        else passed++;
        tick();
        total++;
        if (bus.pred_valid !== 1'b0) $display("FAIL pred_pulse: got %b expected 0", bus.pred_valid);
        else passed++;
        total++;
        if (bus.mispredict_count !== 16'd0) $display("FAIL boot_mcnt: got %0d expected 0", bus.mispredict_count);
        else passed++;
    endtask

    task automatic test_fwd();
        logic pv;
        logic [3:0] pi;
        logic pt;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = 4'd0;
        bus.upd_valid    = 1'b1;
        bus.upd_idx      = 4'd7;
        bus.upd_taken    = 1'b1;
        tick();
        tick();
        bus.upd_valid  = 1'b0;
        bus.lookup_idx = 4'd7;
        #1;
        total++;
        if (bus.lookup_ready !== 1'b0) $display("FAIL fwd_full_stall: got %b expected 0", bus.lookup_ready);
        else passed++;
        tick();
        #1;
`ifdef BPRED_FWD_EN
        total++;
        if (bus.lookup_ready !== 1'b0) $display("FAIL fwd_match_stall: got %b expected 0", bus.lookup_ready);
        else passed++;
        tick();
        #1;
        total++;
        if (bus.lookup_ready !== 1'b1) $display("FAIL fwd_release: got %b expected 1", bus.lookup_ready);
        else passed++;
        tick();
        bus.lookup_valid = 1'b0;
        #1;
        total++;
        if ({bus.pred_valid, bus.pred_idx, bus.pred_taken} !== {1'b1, 4'd7, 1'b1})
            $display("FAIL fwd_pred: got v=%b i=%0d t=%b expected v=1 i=7 t=1", bus.pred_valid, bus.pred_idx, bus.pred_taken);
        else passed++;
`else
        total++;
        if (bus.lookup_ready !== 1'b1) $display("FAIL nofwd_ready: got %b expected 1", bus.lookup_ready);
        else passed++;
        tick();
        bus.lookup_valid = 1'b0;
        #1;
        total++;
        if ({bus.pred_valid, bus.pred_idx, bus.pred_taken} !== {1'b1, 4'd7, 1'b0})
            $display("FAIL nofwd_pred: got v=%b i=%0d t=%b expected v=1 i=7 t=0", bus.pred_valid, bus.pred_idx, bus.pred_taken);
        else passed++;
`endif
        idle(3);
        exp_mcnt = exp_mcnt + 2;
        total++;
        if (bus.mispredict_count !== 16'(exp_mcnt)) $display("FAIL fwd_mcnt: got %0d expected %0d", bus.mispredict_count, exp_mcnt);
        else passed++;
        do_lookup(4'd7, pv, pi, pt);
        total++;
        if (pt !== 1'b1) $display("FAIL fwd_final_taken: got %b expected 1", pt);
        else passed++;
    endtask

    task automatic test_train_taken();
        logic pv;
        logic [3:0] pi;
        logic pt;
        logic exp_t [3];
        exp_t[0] = 1'b0;
        exp_t[1] = 1'b1;
        exp_t[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push_update(4'd3, 1'b1);
            do_lookup(4'd3, pv, pi, pt);
            total++;
            if ({pv, pi, pt} !== {1'b1, 4'd3, exp_t[k]})
                $display("FAIL train_up_%0d: got v=%b i=%0d t=%b expected v=1 i=3 t=%b", k, pv, pi, pt, exp_t[k]);
            else passed++;
        end
        exp_mcnt = exp_mcnt + 2;
        total++;
        if (bus.mispredict_count !== 16'(exp_mcnt)) $display("FAIL train_up_mcnt: got %0d expected %0d", bus.mispredict_count, exp_mcnt);
        else passed++;
    endtask

    task automatic test_train_not_taken();
        logic pv;
        logic [3:0] pi;
        logic pt;
        for (int k = 0; k < 5; k++) push_update(4'd3, 1'b0);
        exp_mcnt = exp_mcnt + 2;
        total++;
        if (bus.mispredict_count !== 16'(exp_mcnt)) $display("FAIL train_dn_mcnt: got %0d expected %0d", bus.mispredict_count, exp_mcnt);
        else passed++;
        do_lookup(4'd3, pv, pi, pt);
        total++;
        if (pt !== 1'b0) $display("FAIL train_dn_taken: got %b expected 0", pt);
        else passed++;
        // From a held 00, one taken gives 01 (still not-taken), a second gives 10.
        push_update(4'd3, 1'b1);
        do_lookup(4'd3, pv, pi, pt);
        total++;
        if (pt !== 1'b0) $display("FAIL sat_low_step1: got %b expected 0", pt);
        else passed++;
        push_update(4'd3, 1'b1);
        do_lookup(4'd3, pv, pi, pt);
        total++;
        if (pt !== 1'b1) $display("FAIL sat_low_step2: got %b expected 1", pt);
        else passed++;
        exp_mcnt = exp_mcnt + 2;
        total++;
        if (bus.mispredict_count !== 16'(exp_mcnt)) $display("FAIL sat_low_mcnt: got %0d expected %0d", bus.mispredict_count, exp_mcnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic pv;
        logic [3:0] pi;
        logic pt;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = 4'd9;
        bus.upd_valid    = 1'b1;
        bus.upd_idx      = 4'd10;
        bus.upd_taken    = 1'b1;
        #1;
        total++;
        if ({bus.upd_ready, bus.lookup_ready} !== 2'b11)
            $display("FAIL b2b_c0_ready: got upd=%b lk=%b expected 1 1", bus.upd_ready, bus.lookup_ready);
        else passed++;
        tick();
        #1;
        total++;
        if ({bus.upd_ready, bus.lookup_ready, bus.pred_valid, bus.pred_idx, bus.pred_taken} !== {3'b111, 4'd9, 1'b0})
            $display("FAIL b2b_c1: got upd=%b lk=%b pv=%b pi=%0d pt=%b expected 1 1 1 9 0",
                     bus.upd_ready, bus.lookup_ready, bus.pred_valid, bus.pred_idx, bus.pred_taken);
        else passed++;
        tick();
        #1;
        total++;
        if ({bus.upd_ready, bus.lookup_ready} !== 2'b00)
            $display("FAIL b2b_full_ready: got upd=%b lk=%b expected 0 0", bus.upd_ready, bus.lookup_ready);
        else passed++;
        tick();
        #1;
        total++;
        if ({bus.pred_valid, bus.upd_ready, bus.lookup_ready} !== 3'b011)
            $display("FAIL b2b_after_drain: got pv=%b upd=%b lk=%b expected 0 1 1", bus.pred_valid, bus.upd_ready, bus.lookup_ready);
        else passed++;
        tick();
        bus.upd_valid = 1'b0;
        #1;
        total++;
        if ({bus.upd_ready, bus.lookup_ready} !== 2'b00)
            $display("FAIL b2b_refull_ready: got upd=%b lk=%b expected 0 0", bus.upd_ready, bus.lookup_ready);
        else passed++;
        tick();
        bus.lookup_valid = 1'b0;
        idle(3);
        exp_mcnt = exp_mcnt + 2;
        total++;
        if (bus.mispredict_count !== 16'(exp_mcnt)) $display("FAIL b2b_mcnt: got %0d expected %0d", bus.mispredict_count, exp_mcnt);
        else passed++;
        do_lookup(4'd10, pv, pi, pt);
        total++;
        if (pt !== 1'b1) $display("FAIL b2b_entry10: got %b expected 1", pt);
        else passed++;
    endtask

    task automatic test_reset_mid_fifo();
        logic pv;
        logic [3:0] pi;
        logic pt;
        bus.lookup_valid = 1'b1;
        bus.lookup_idx   = 4'd5;
        bus.upd_valid    = 1'b1;
        bus.upd_idx      = 4'd2;
        bus.upd_taken    = 1'b1;
        tick();
        tick();
        bus.upd_valid    = 1'b0;
        bus.lookup_valid = 1'b0;
        reset            = 1'b1;
        #1;
        total++;
        if (bus.upd_ready !== 1'b0) $display("FAIL mid_fifo_full: got %b expected 0", bus.upd_ready);
        else passed++;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({bus.pred_valid, bus.pred_idx, bus.pred_taken, bus.init_busy} !== {1'b0, 4'd0, 1'b0, 1'b1})
            $display("FAIL mid_rst_state: got pv=%b pi=%0d pt=%b busy=%b expected 0 0 0 1",
                     bus.pred_valid, bus.pred_idx, bus.pred_taken, bus.init_busy);
        else passed++;
        total++;
        if (bus.mispredict_count !== 16'd0) $display("FAIL mid_rst_mcnt: got %0d expected 0", bus.mispredict_count);
        else passed++;
        count_init("restart");
        idle(4);
        total++;
        if (bus.mispredict_count !== 16'd0) $display("FAIL mid_no_drain_mcnt: got %0d expected 0", bus.mispredict_count);
        else passed++;
        do_lookup(4'd2, pv, pi, pt);
        total++;
        if (pt !== 1'b0) $display("FAIL mid_entry2: got %b expected 0", pt);
        else passed++;
        do_lookup(4'd10, pv, pi, pt);
        total++;
        if (pt !== 1'b0) $display("FAIL mid_entry10_cleared: got %b expected 0", pt);
        else passed++;
    endtask

    initial begin
        passed           = 0;
        total            = 0;
        exp_mcnt         = 0;
        reset            = 1'b1;
        bus.lookup_valid = 1'b0;
        bus.lookup_idx   = 4'd0;
        bus.upd_valid    = 1'b0;
        bus.upd_idx      = 4'd0;
        bus.upd_taken    = 1'b0;
        test_reset();
        test_fwd();
        test_train_taken();
        test_train_not_taken();
        test_back_to_back();
        test_reset_mid_fifo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bpred_ctrl.md
BPRED_CTRL -- requirements
Module: bpred_ctrl

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of 2-bit counter entries (power of 2, ≥4).
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the index width, equal to log2(ENTRIES).
REQ-003 The block SHALL have parameter MCNT_W, default 16, meaning the mispredict counter width.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port lookup_valid  input  1  a prediction request is present.
REQ-007 Port lookup_ready  output  1  the block accepts the lookup this cycle.
REQ-008 Port lookup_idx  input  IDX_W  entry to predict.
REQ-009 Port pred_valid  output  1  prediction result valid (single-cycle pulse).
REQ-010 Port pred_idx  output  IDX_W  echo of the accepted lookup_idx.
REQ-011 Port pred_taken  output  1  MSB of the entry read.
REQ-012 Port upd_valid  input  1  a resolved-branch update is present.
REQ-013 Port upd_ready  output  1  update accepted this cycle.
REQ-014 Port upd_idx  input  IDX_W  entry to train.
REQ-015 Port upd_taken  input  1  actual branch outcome.
REQ-016 Port init_busy  output  1  table initialisation sweep in progress.
REQ-017 Port mispredict_count  output  MCNT_W  saturating count of mispredicted updates.

Function
REQ-018 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT with sweep pointer 0.
REQ-019 In INIT, the block SHALL write 2'b00 to entry[ptr] each cycle, increment ptr, and go to RUN after writing entry ENTRIES-1 (ENTRIES cycles total); init_busy=1, lookup_ready=0, upd_ready=0.
REQ-020 In RUN, init_busy SHALL be 0; the table SHALL perform at most one access per cycle (a lookup read or an update read-modify-write).
REQ-021 An update accepted (upd_valid&&upd_ready) SHALL enter a 2-deep FIFO; upd_ready SHALL equal FIFO-not-full at cycle start, with no same-cycle pass-through.
REQ-022 Arbitration SHALL work as follows: if the FIFO is full, the drain wins and lookup_ready=0; otherwise, if lookup_valid, the lookup wins; otherwise the FIFO drains when non-empty.
REQ-023 An accepted lookup SHALL produce pred_valid=1 exactly one cycle later, with pred_idx = the accepted index and pred_taken = the entry MSB as of the acceptance cycle; otherwise pred_valid=0.
REQ-024 On drain, the entry SHALL increment if taken and !=2'b11, decrement if not-taken and !=2'b00, and otherwise hold.
REQ-025 On drain, if taken != old entry MSB, mispredict_count SHALL increment, saturating at all-ones.
REQ-026 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged and preserve FIFO order.
REQ-027 Updates to the same index SHALL apply in acceptance order.

Reset
REQ-028 On reset the block SHALL force pred_valid=0, pred_idx=0, pred_taken=0, lookup_ready=0, upd_ready=0, init_busy=1 (from the next cycle), mispredict_count=0, and an empty FIFO.
REQ-029 Reset asserted mid-sweep or mid-RUN SHALL discard all queued updates and pending predictions, and SHALL restart INIT from entry 0.

Configuration
REQ-030 With macro BPRED_FWD_EN defined, a lookup whose idx matches any queued FIFO entry SHALL be stalled (lookup_ready=0), and the FIFO SHALL drain, until no match remains.
REQ-031 Without BPRED_FWD_EN, lookups SHALL read the table as-is, ignoring queued updates.

Structure
REQ-032 Package bpred_pkg SHALL hold the 2-bit counter typedef, the constants SNT=00, WNT=01, WT=10 and ST=11, the FSM state enum, and the update-record struct {idx, taken}.
REQ-033 The update FIFO SHALL be a sub-module, bpred_upd_fifo (parameterised record, 2 entries, full/empty flags).

Verification
REQ-034 Reset is released -> init_busy=1 for 16 cycles, then 0; a lookup of idx 5 gives pred_taken=0, and mispredict_count=0.
REQ-035 Three updates idx 3 taken, then lookup idx 3 -> entry goes 00→01→10→11, pred_taken=1, mispredict_count=2.
REQ-036 Idx 3 at 11, then five not-taken updates -> entry saturates at 00, and mispredict_count increases by 2.
REQ-037 With lookup_valid held high and three back-to-back updates -> upd_ready drops after 2, the drain wins when the FIFO is full, and lookup_ready=0 in that cycle.
REQ-038 Reset pulsed with the FIFO holding 2 updates -> no entry changes from them, and the INIT sweep restarts at 0.
REQ-039 With BPRED_FWD_EN, an update on idx 7 is queued and then idx 7 is looked up -> the lookup stalls until the drain, and pred_taken reflects the updated entry.
